// File: rtl/rx_iq_packer_if.sv
// rtl/rx_iq_packer_if.sv - sample input and byte-stream output bundle for rx_iq_packer
interface rx_iq_packer_if;
  logic               in_strobe;
  logic signed [23:0] in_data_I;
  logic signed [23:0] in_data_Q;
  logic        [15:0] mic_data;
  logic        [7:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;

  modport master (
    output in_strobe,
    output in_data_I,
    output in_data_Q,
    output mic_data,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  out_last
  );

  modport slave (
    input  in_strobe,
    input  in_data_I,
    input  in_data_Q,
    input  mic_data,
    input  out_ready,
    output out_data,
    output out_valid,
    output out_last
  );
endinterface

// File: rtl/rx_iq_packer.sv
// rtl/rx_iq_packer.sv - packs IQ+mic samples into a FIFO of 64-bit words and
// serialises them MSB-first as an 8-bit stream framed in SAMPLES_PER_BLOCK blocks.
module rx_iq_packer #(
  parameter int FIFO_DEPTH        = 16,
  parameter int SAMPLES_PER_BLOCK = 63
) (
  input  logic                        clock,
  input  logic                        reset_n,
  rx_iq_packer_if.slave               s,
  output logic                        overflow,
  input  logic                        clear_overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (SAMPLES_PER_BLOCK > 1) ? $clog2(SAMPLES_PER_BLOCK) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(SAMPLES_PER_BLOCK - 1);
  localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(FIFO_DEPTH);

  logic [63:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [2:0]    byte_idx_q, byte_idx_d;
  logic [CW-1:0] sample_cnt_q, sample_cnt_d;
  logic          overflow_q, overflow_d;

  logic          valid;
  logic          xfer;
  logic          last_byte;
  logic          pop;
  logic          full;
  logic          push;
  logic          drop;
  logic [63:0]   head_word;
  logic [7:0]    head_byte;

  assign valid     = (level_q != '0);
  assign xfer      = valid & s.out_ready;
  assign last_byte = (byte_idx_q == 3'd7);
  assign pop       = xfer & last_byte;
  assign full      = (level_q == LEVEL_FULL);
  // A pop on the same edge frees the slot, so a full FIFO can still take a sample.
  assign push      = s.in_strobe & (~full | pop);
  assign drop      = s.in_strobe & full & ~pop;
  assign head_word = mem_q[rd_ptr_q];

  always_comb begin
    head_byte = 8'h00;
    case (byte_idx_q)
      3'd0: head_byte = head_word[63:56];
      3'd1: head_byte = head_word[55:48];
      3'd2: head_byte = head_word[47:40];
      3'd3: head_byte = head_word[39:32];
      3'd4: head_byte = head_word[31:24];
      3'd5: head_byte = head_word[23:16];
      3'd6: head_byte = head_word[15:8];
      3'd7: head_byte = head_word[7:0];
      default: head_byte = 8'h00;
    endcase
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    byte_idx_d   = byte_idx_q;
    sample_cnt_d = sample_cnt_q;
    overflow_d   = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      sample_cnt_d = (sample_cnt_q == CNT_LAST) ? '0 : sample_cnt_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (xfer) begin
      byte_idx_d = byte_idx_q + 3'd1;
    end
    // A drop on the same edge as a clear must leave the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      byte_idx_q   <= '0;
      sample_cnt_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      byte_idx_q   <= byte_idx_d;
      sample_cnt_q <= sample_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset: nothing is read unless level_q counts it as written.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s.in_data_I, s.in_data_Q, s.mic_data};
    end
  end

  assign s.out_valid = valid;
  assign s.out_data  = valid ? head_byte : 8'h00;
  assign s.out_last  = valid & last_byte & (sample_cnt_q == CNT_LAST);
  assign overflow    = overflow_q;
  assign fifo_level  = level_q;

endmodule

// File: tb/tb_rx_iq_packer.sv
// tb/tb_rx_iq_packer.sv - randomized scoreboard bench for rx_iq_packer
module tb_rx_iq_packer;
  localparam int DEPTH = 16;
  localparam int SPB   = 63;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       clear_overflow = 1'b0;
  logic       overflow;
  logic [4:0] fifo_level;

  rx_iq_packer_if ifc();

  rx_iq_packer #(.FIFO_DEPTH(DEPTH), .SAMPLES_PER_BLOCK(SPB)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .s              (ifc.slave),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .fifo_level     (fifo_level)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_byte_t;

  exp_byte_t   exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          k = 0;
  bit          exp_ovf = 1'b0;
  bit          pend_ovf = 1'b0;
  bit          pend_push = 1'b0;
  logic [63:0] pend_word = '0;
  bit          monitor_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Accepted samples leave in order, so the n-th accepted sample since reset
  // is sample n mod SPB of its block.
  task automatic commit();
    exp_byte_t e;
    if (pend_push) begin
      for (int b = 0; b < 8; b++) begin
        e.data = pend_word[63 - 8*b -: 8];
        e.last = (b == 7) && ((k % SPB) == SPB - 1);
        exp_q.push_back(e);
      end
      k++;
      pend_push = 1'b0;
    end
    exp_ovf = pend_ovf;
  endtask

  task automatic step(input bit st, input bit rd, input bit clr,
                      input logic [23:0] di, input logic [23:0] dq, input logic [15:0] dm);
    int  words;
    bit  pop_now;
    bit  full_now;
    @(posedge clock);
    #1;
    commit();
    ifc.in_strobe  = st;
    ifc.in_data_I  = di;
    ifc.in_data_Q  = dq;
    ifc.mic_data   = dm;
    ifc.out_ready  = rd;
    clear_overflow = clr;
    words    = (exp_q.size() + 7) / 8;
    pop_now  = rd && (exp_q.size() % 8 == 1);
    full_now = (words == DEPTH);
    if (st && (!full_now || pop_now)) begin
      pend_push = 1'b1;
      pend_word = {di, dq, dm};
    end
    if (st && full_now && !pop_now) pend_ovf = 1'b1;
    else if (clr)                   pend_ovf = 1'b0;
    else                            pend_ovf = exp_ovf;
  endtask

  task automatic rstep(input bit st, input bit rd, input bit clr);
    step(st, rd, clr, 24'($urandom), 24'($urandom), 16'($urandom));
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(ifc.out_valid), 64'd0);
    chk({tag, "_out_last"},  64'(ifc.out_last),  64'd0);
    chk({tag, "_overflow"},  64'(overflow),      64'd0);
    chk({tag, "_level"},     64'(fifo_level),    64'd0);
    chk({tag, "_out_data"},  64'(ifc.out_data),  64'd0);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero_outputs(tag);
    exp_q.delete();
    pend_push = 1'b0;
    pend_ovf  = 1'b0;
    exp_ovf   = 1'b0;
    k = 0;
    ifc.in_strobe  = 1'b0;
    ifc.out_ready  = 1'b0;
    clear_overflow = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || pend_push) && n < 2000) begin
      rstep(1'b0, 1'b1, 1'b0);
      n++;
    end
    chk("drain_bytes_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic stream(input int nsamp);
    for (int i = 0; i < nsamp; i++) begin
      rstep(1'b1, 1'b1, 1'b0);
      repeat (7) rstep(1'b0, 1'b1, 1'b0);
    end
  endtask

  always @(negedge clock) begin
    if (monitor_on) begin
      chk("out_valid",  64'(ifc.out_valid), 64'(exp_q.size() != 0));
      chk("fifo_level", 64'(fifo_level),    64'((exp_q.size() + 7) / 8));
      chk("overflow",   64'(overflow),      64'(exp_ovf));
      if (exp_q.size() != 0) begin
        chk("out_data", 64'(ifc.out_data), 64'(exp_q[0].data));
        chk("out_last", 64'(ifc.out_last), 64'(exp_q[0].last));
        if (ifc.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    ifc.in_strobe = 1'b0;
    ifc.in_data_I = '0;
    ifc.in_data_Q = '0;
    ifc.mic_data  = '0;
    ifc.out_ready = 1'b0;
    #1;
    reset_n = 1'b0;
    #10;
    check_zero_outputs("reset");
    @(negedge clock);
    #2;
    reset_n = 1'b1;
    monitor_on = 1'b1;

    // Known single sample, consumer always ready.
    step(1'b1, 1'b1, 1'b0, 24'h123456, 24'hABCDEF, 16'h0102);
    repeat (10) rstep(1'b0, 1'b1, 1'b0);

    // Random traffic with random back-pressure and occasional clears.
    for (int i = 0; i < 800; i++) begin
      rstep($urandom_range(0, 5) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
    end
    drain();

    // Fill past full with the consumer stalled, then clear the sticky flag.
    repeat (17) rstep(1'b1, 1'b0, 1'b0);
    repeat (2) rstep(1'b0, 1'b0, 1'b0);
    rstep(1'b1, 1'b0, 1'b1);
    rstep(1'b0, 1'b0, 1'b1);
    rstep(1'b0, 1'b0, 1'b0);

    // Full FIFO with concurrent pop and push on every word boundary.
    repeat (40) rstep(1'b1, 1'b1, 1'b0);

    // Alternating ready mid-word.
    for (int i = 0; i < 40; i++) rstep(1'b0, (i % 2) == 0, 1'b0);
    drain();

    // Fresh block framing from reset: 64 samples back to back.
    pulse_reset("mid_reset1");
    stream(64);
    drain();

    // Reset in the middle of sample 10, then a full block from the restart.
    pulse_reset("mid_reset2");
    stream(10);
    repeat (4) rstep(1'b0, 1'b1, 1'b0);
    pulse_reset("mid_reset3");
    stream(64);
    drain();

    repeat (3) rstep(1'b0, 1'b1, 1'b0);
    monitor_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
